fifo_cmd_arbiter: RTL
=====================

// Module: fifo_cmd_arbiter
// PURPOSE
//  Upstream command stage for the inter-core fifo. Accepts write requests (producer core) and read
//  requests (consumer core) over valid/ready, arbitrates round-robin, and drives the fifo's packed
//  command vector {opcode, data, strobe} one op at a time with a NOP gap. Tracks occupancy itself,
//  registers read data back to the consumer with a 1-cycle valid pulse.
// PARAMETERS
//  DATA_WIDTH   4   payload width
//  OPCODE_WIDTH 2   command opcode width
//  EXTRA_BIT    1   strobe bit width
//  LINE_WIDTH   DATA_WIDTH+OPCODE_WIDTH+EXTRA_BIT   command vector width (7)
//  NUM_ENTRIES  2   fifo depth; occupancy ceiling
//  OCC_WIDTH    2   occupancy width, holds 0..NUM_ENTRIES
// PORTS
//  clk            in   1            rising-edge clock
//  reset          in   1            reset, synchronous, active-high
//  wr_req_valid   in   1            producer has data to write
//  wr_req_data    in   DATA_WIDTH   write payload
//  wr_req_ready   out  1            write accepted when valid&&ready
//  rd_req_valid   in   1            consumer requests one word
//  rd_req_ready   out  1            read accepted when valid&&ready
//  rd_data        out  DATA_WIDTH   returned word (registered)
//  rd_data_valid  out  1            1-cycle pulse, rd_data valid
//  fifo_data_in   in   DATA_WIDTH   fifo data_out
//  vector_out     out  LINE_WIDTH   fifo command vector
//  occupancy      out  OCC_WIDTH    words held in fifo
//  busy           out  1            op in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (sync): state=IDLE, vector_out=0 (NOP), rd_data=0, rd_data_valid=0, occupancy=0,
//    last_grant=READ (write wins first tie), busy=0. Fifo reset is the same net.
//  - vector_out = {opcode[LINE-1:LINE-2], data[LINE-3:1], strobe[0]}; READ=2'b01, WRITE=2'b10,
//    NOP=2'b00; strobe=1 on READ/WRITE, 0 on NOP; data field 0 on READ/NOP. Registered output.
//  - Eligibility: write_ok = wr_req_valid && occupancy<NUM_ENTRIES; read_ok = rd_req_valid &&
//    occupancy!=0. Ineligible requests are held off (ready=0), never dropped.
//  - Ready is combinational, asserted only in IDLE, at most one of wr/rd ready per cycle.
//  - Arbitration: one eligible -> grant it; both -> grant opposite of last_grant; update on grant.
//  - FSM: IDLE -(grant)-> ISSUE -> GAP -> IDLE. No grant in ISSUE/GAP.
//    ISSUE: vector_out = op command for exactly 1 cycle. GAP: vector_out = NOP for 1 cycle.
//  - Latency: accept at cycle N; command on vector_out N+1; NOP N+2; next accept earliest N+3.
//    Throughput: one op per 3 cycles.
//  - Read return: fifo_data_in sampled at the edge ending ISSUE; rd_data/rd_data_valid=1 in GAP
//    only; rd_data holds value until next read.
//  - Occupancy: +1 at edge ending ISSUE for WRITE, -1 for READ; never wraps (guarded by eligibility);
//    saturates structurally at 0 and NUM_ENTRIES.
//  - Request deasserted after acceptance has no effect; payload latched at acceptance.
//  - Reset mid-op (ISSUE/GAP): op abandoned, all state to reset values next edge, no rd_data_valid.
// STRUCTURE
//  - Shared package fifo_cmd_pkg: opcode constants READ/WRITE/NOP, state encoding
//    IDLE/ISSUE/GAP, LOG2 macro, LINE_WIDTH derivation, shared with fifo.
//  - One sub-module: rr_arbiter2 (2-requester round-robin, last_grant register, one-hot grant).
//  - Top: FSM, payload/op latch, occupancy counter, vector_out and rd_data registers.
// TESTING
//  1. Reset: hold reset 2 cycles -> vector_out=7'b0, occupancy=0, both ready per eligibility, no pulse.
//  2. Write 4'hA: accept N -> vector_out=7'b10_1010_1 at N+1, 7'b0 at N+2, occupancy=1 from N+2.
//  3. Fill: writes 4'h3,4'h5 -> occupancy=2; third write valid held -> wr_req_ready=0 until a read.
//  4. Read after fill: vector_out=7'b01_0000_1, rd_data=4'h3 with rd_data_valid 1 cycle, occupancy=1.
//  5. Tie: occ=1, wr+rd valid together -> write granted first, read next op, then alternate.
//  6. Empty read held (rd_req_ready=0); reset asserted in ISSUE -> NOP next, occupancy=0, no pulse.

Source files
------------

// File: rtl/fifo_cmd_pkg.sv
// Shared definitions for the inter-core fifo and its command stage:
// widths, opcode and state encodings, command-vector builder.
package fifo_cmd_pkg;

  // Ceiling log2, used to size counters that must hold 0..N inclusive.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned DATA_WIDTH   = 4;
  localparam int unsigned OPCODE_WIDTH = 2;
  localparam int unsigned EXTRA_BIT    = 1;
  localparam int unsigned LINE_WIDTH   = DATA_WIDTH + OPCODE_WIDTH + EXTRA_BIT;
  localparam int unsigned NUM_ENTRIES  = 2;
  localparam int unsigned OCC_WIDTH    = log2(NUM_ENTRIES + 1);

  localparam logic [OCC_WIDTH-1:0] OCC_MAX = OCC_WIDTH'(NUM_ENTRIES);

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  // {opcode, data, strobe}; data field is zero for anything but a write.
  function automatic logic [LINE_WIDTH-1:0] make_cmd(input opcode_t op,
                                                     input logic [DATA_WIDTH-1:0] d);
    return {op, (op == OP_WRITE) ? d : DATA_WIDTH'(0), op != OP_NOP};
  endfunction

endpackage

// File: rtl/fifo_cmd_arbiter_if.sv
// Request/response and fifo-command signals of the command stage.
interface fifo_cmd_arbiter_if;
  import fifo_cmd_pkg::*;

  logic                  wr_req_valid;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_req_ready;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic [LINE_WIDTH-1:0] vector_out;
  logic [OCC_WIDTH-1:0]  occupancy;
  logic                  busy;

  modport master (
    output wr_req_valid, wr_req_data, rd_req_valid, fifo_data_in,
    input  wr_req_ready, rd_req_ready, rd_data, rd_data_valid,
           vector_out, occupancy, busy
  );

  modport slave (
    input  wr_req_valid, wr_req_data, rd_req_valid, fifo_data_in,
    output wr_req_ready, rd_req_ready, rd_data, rd_data_valid,
           vector_out, occupancy, busy
  );
endinterface

// File: rtl/fifo_cmd_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 = write, bit 1 = read.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Starts as "read last" so the first tie goes to the write side.
  logic last_read;

  always_comb begin
    grant = '0;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_read ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        last_read <= 1'b1;
    else if (|grant)  last_read <= grant[1];
  end

endmodule

// File: rtl/fifo_cmd_arbiter.sv
// Command stage for the inter-core fifo: arbitrates write/read requests and
// issues one command per three cycles, tracking fifo occupancy locally.
module fifo_cmd_arbiter
  import fifo_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fifo_cmd_arbiter_if.slave bus
);

  state_t                state, state_next;
  opcode_t               op_q;
  logic [1:0]            req, grant;
  logic                  arb_en, busy;
  logic                  write_ok, read_ok;
  logic [LINE_WIDTH-1:0] vec_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic [OCC_WIDTH-1:0]  occ;

  assign write_ok = bus.wr_req_valid && (occ < OCC_MAX);
  assign read_ok  = bus.rd_req_valid && (occ != '0);
  assign req      = {read_ok, write_ok};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|grant) state_next = ISSUE;
      ISSUE:   state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    arb_en = (state == IDLE);
    busy   = (state != IDLE);
  end

  // The command is built at acceptance so the payload is frozen there;
  // the fifo acts on it at the edge ending ISSUE, when occupancy and read data update.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      occ        <= '0;
      op_q       <= OP_NOP;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant[0]) begin
            op_q  <= OP_WRITE;
            vec_q <= make_cmd(OP_WRITE, bus.wr_req_data);
          end else if (grant[1]) begin
            op_q  <= OP_READ;
            vec_q <= make_cmd(OP_READ, bus.wr_req_data);
          end
        end
        ISSUE: begin
          vec_q <= make_cmd(OP_NOP, '0);
          if (op_q == OP_WRITE) begin
            if (occ != OCC_MAX) occ <= occ + OCC_WIDTH'(1);
          end else if (op_q == OP_READ) begin
            if (occ != '0) occ <= occ - OCC_WIDTH'(1);
            rd_data_q  <= bus.fifo_data_in;
            rd_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_req_ready  = grant[0];
  assign bus.rd_req_ready  = grant[1];
  assign bus.vector_out    = vec_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.occupancy     = occ;
  assign bus.busy          = busy;

endmodule
